// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: request/response bus between the MEM stage and the data memory
interface data_memory_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: big-endian byte-addressed data memory with handshake, wait states and init sequencer
// Optional macro DMEM_PERF_CNT_EN adds saturating load/store/error counters.
module data_memory_ctrl #(
    parameter int          DEPTH_BYTES = 64,
    parameter int          ADDR_W      = 32,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] INIT_WORD   = 32'h0000_0001
) (
    input  logic clk,
    input  logic rst,
    input  logic init_start,
    output logic init_busy,
`ifdef DMEM_PERF_CNT_EN
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] err_count,
`endif
    data_memory_ctrl_if.slave bus
);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IW = $clog2(DEPTH_BYTES);
    localparam int KW = $clog2(WORDS);
    localparam logic [3:0] WLAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH_BYTES];
    logic [KW-1:0]     k;
    logic [3:0]        wcnt;
    logic              lat_write, lat_unsigned;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              hold_err;
    logic [31:0]       hold_rdata;
    logic              cur_write, cur_unsigned;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [ADDR_W:0]   nbytes, end_addr;
    logic [IW-1:0]     a0, a1, a2, a3;
    logic [7:0]        b0, b1, b2, b3;
    logic              sx, err, accept, enter_resp;
    logic [31:0]       ld_data, rdata_n;

    assign accept = state == IDLE && bus.req_valid && !init_start;
    assign enter_resp = !rst && ((accept && WAIT_STATES == 0) || (state == WAIT && wcnt == WLAST));

    // Decode the live request on a zero-wait acceptance, otherwise the latched one
    always_comb begin
        cur_write    = state == IDLE ? bus.req_write : lat_write;
        cur_size     = state == IDLE ? bus.req_size : lat_size;
        cur_unsigned = state == IDLE ? bus.req_unsigned : lat_unsigned;
        cur_addr     = state == IDLE ? bus.req_addr : lat_addr;
        cur_wdata    = state == IDLE ? bus.req_wdata : lat_wdata;
        nbytes   = (ADDR_W + 1)'(cur_size == 2'b00 ? 1 : cur_size == 2'b01 ? 2 : 4);
        end_addr = {1'b0, cur_addr} + nbytes;
        err = cur_size == 2'b11 || (cur_size == 2'b01 && cur_addr[0]) ||
              (cur_size == 2'b10 && cur_addr[1:0] != 2'b00) || end_addr > (ADDR_W + 1)'(DEPTH_BYTES);
        a0 = cur_addr[IW-1:0];
        a1 = a0 + IW'(1);
        a2 = a0 + IW'(2);
        a3 = a0 + IW'(3);
        b0 = mem[a0];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];
        sx = !cur_unsigned && b0[7];
        ld_data = cur_size == 2'b10 ? {b0, b1, b2, b3} :
                  cur_size == 2'b01 ? {{16{sx}}, b0, b1} : {{24{sx}}, b0};
        rdata_n = (err || cur_write) ? 32'h0 : ld_data;
    end

    // Storage: one word per cycle while initialising, big-endian stores on the edge entering RESP
    always_ff @(posedge clk) begin
        if (!rst && state == INIT) begin
            mem[{k, 2'b00}] <= INIT_WORD[31:24];
            mem[{k, 2'b01}] <= INIT_WORD[23:16];
            mem[{k, 2'b10}] <= INIT_WORD[15:8];
            mem[{k, 2'b11}] <= INIT_WORD[7:0];
        end else if (enter_resp && cur_write && !err) begin
            mem[a0] <= cur_size == 2'b00 ? cur_wdata[7:0] : cur_size == 2'b01 ? cur_wdata[15:8] : cur_wdata[31:24];
            if (cur_size != 2'b00) mem[a1] <= cur_size == 2'b01 ? cur_wdata[7:0] : cur_wdata[23:16];
            if (cur_size == 2'b10) begin
                mem[a2] <= cur_wdata[15:8];
                mem[a3] <= cur_wdata[7:0];
            end
        end
    end

    // Control FSM; outputs are registered so the response appears the cycle after RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= INIT;
            k               <= '0;
            wcnt            <= '0;
            init_busy       <= 1'b1;
            bus.req_ready   <= 1'b0;
            bus.resp_valid  <= 1'b0;
            bus.resp_rdata  <= '0;
            bus.resp_error  <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_error <= 1'b0;
            case (state)
                INIT: begin
                    k <= k + 1'b1;
                    if (k == KW'(WORDS - 1)) begin
                        state         <= IDLE;
                        init_busy     <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (init_start) begin
                        state         <= INIT;
                        k             <= '0;
                        init_busy     <= 1'b1;
                        bus.req_ready <= 1'b0;
                    end else if (bus.req_valid) begin
                        state         <= WAIT_STATES == 0 ? RESP : WAIT;
                        wcnt          <= '0;
                        bus.req_ready <= 1'b0;
                        lat_write     <= bus.req_write;
                        lat_size      <= bus.req_size;
                        lat_unsigned  <= bus.req_unsigned;
                        lat_addr      <= bus.req_addr;
                        lat_wdata     <= bus.req_wdata;
                    end
                end
                WAIT: begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == WLAST) state <= RESP;
                end
                RESP: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= hold_rdata;
                    bus.resp_error <= hold_err;
                end
                default: state <= INIT;
            endcase
            if (enter_resp) begin
                hold_rdata <= rdata_n;
                hold_err   <= err;
            end
        end
    end

`ifdef DMEM_PERF_CNT_EN
    // Saturating access counters, advanced once per response; only rst clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else if (state == RESP) begin
            if (hold_err) err_count <= err_count + {15'd0, err_count != 16'hFFFF};
            else if (lat_write) wr_count <= wr_count + {15'd0, wr_count != 16'hFFFF};
            else rd_count <= rd_count + {15'd0, rd_count != 16'hFFFF};
        end
    end
`endif
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised, byte-addressed, big-endian data memory for the pipelined CPU's MEM stage. It generalises the fixed 40-byte word-only store with the following additions:
- configurable depth
- byte, halfword and word accesses with sign or zero extension
- a valid/ready request handshake with a configurable number of wait states
- a multi-cycle initialisation sequencer
- misalignment and out-of-range error reporting

The CPU stalls on req_ready/resp_valid.

Parameters:
DEPTH_BYTES, 64, memory size in bytes; multiple of 4, minimum 8
ADDR_W, 32, request address width
WAIT_STATES, 2, extra cycles between acceptance and response (0..15)
INIT_WORD, 32'h0000_0001, word written to every aligned word during initialisation

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
init_start  in  1  pulse: refill memory with INIT_WORD
init_busy  out  1  high while initialisation is running
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data; the low bytes are used for byte/half stores
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load data; 0 for stores and errors
resp_error  out  1  qualifies resp_valid

Behaviour:
- FSM states: INIT, IDLE, WAIT, RESP.
- Reset:
  - rst in any state goes to INIT next cycle; any pending request is discarded.
  - Output values during reset: resp_valid=0, resp_rdata=0, resp_error=0, req_ready=0, init_busy=1.
- INIT:
  - Writes INIT_WORD to word index k (bytes 4k..4k+3) on cycle k.
  - Lasts DEPTH_BYTES/4 cycles, then goes to IDLE.
  - init_busy=1 and req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - init_start=1 goes to INIT; it has priority over a simultaneous req_valid, which is not accepted.
  - init_start outside IDLE is ignored.
- Acceptance edge (IDLE && req_valid): all request fields are latched.
  - With WAIT_STATES>0 the FSM goes to WAIT, where a counter runs WAIT_STATES cycles, then to RESP.
  - With WAIT_STATES=0 it goes directly to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- Latency: a request accepted at edge N has resp_valid high during the cycle after edge N+WAIT_STATES+1.
- Error check on the latched request. Any of these is an error:
  - req_size==11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr + bytes > DEPTH_BYTES, computed without wrap (ADDR_W+1 bits)
- On error: no memory write, resp_rdata=0, resp_error=1.
- Store: memory is written on the edge entering RESP, big-endian.
  - Word: m[a]=wdata[31:24] .. m[a+3]=wdata[7:0].
  - Half: m[a]=wdata[15:8], m[a+1]=wdata[7:0].
  - Byte: m[a]=wdata[7:0].
- Load: data is sampled on the edge entering RESP, so it reflects all earlier stores.
  - Word: {m[a], m[a+1], m[a+2], m[a+3]}.
  - Half and byte are sign- or zero-extended per req_unsigned.
- resp_rdata and resp_error are held at 0 whenever resp_valid=0.
- Memory contents are undefined until the first INIT completes, which is guaranteed after reset.

Optional Feature:
Macro DMEM_PERF_CNT_EN.
- Defined: adds outputs rd_count[15:0], wr_count[15:0] and err_count[15:0].
  - Each counter increments in the RESP cycle of a successful load, a successful store, or an error respectively.
  - The counters saturate at 16'hFFFF and are cleared by rst.
  - They are not cleared by init_start.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst high for 2 cycles, then low; init_busy high for 16 cycles (DEPTH_BYTES=64), then req_ready=1; a word load at addr 0x0C returns 32'h0000_0001 with resp_error=0.
- Word store 0xDEADBEEF at 0x10, then loads: byte signed at 0x10 -> 0xFFFFFFDE; byte unsigned at 0x13 -> 0x000000EF; half signed at 0x12 -> 0xFFFFBEEF; word at 0x10 -> 0xDEADBEEF.
- Latency: WAIT_STATES=2, request accepted at edge N -> resp_valid only in the cycle after edge N+3, req_ready=0 in between; with WAIT_STATES=0 -> response after edge N+1.
- Errors:
  - word load at 0x02 -> resp_error=1, rdata=0
  - half store at 0x3F -> error, memory unchanged
  - word at 0x3C -> OK
  - word at 0x40 -> error
  - size 11 -> error
- Mid-operation events:
  - rst asserted in WAIT -> no resp_valid; INIT restarts, memory refilled.
  - init_start together with req_valid in IDLE -> request not accepted, INIT runs.
  - init_start in WAIT -> ignored.
- With DMEM_PERF_CNT_EN: 3 loads, 2 stores, 1 error -> rd_count=3, wr_count=2, err_count=1; the counters persist across init_start and clear on rst.
